// File: rtl/haunt_effect_ctrl.sv
// Haunted-decoration effect controller: turns one-hot decoded commands into
// registered lamp, sound, movement and fog actuator drive.
module haunt_effect_ctrl #(
    parameter int unsigned SOUND_CYCLES    = 8,
    parameter int unsigned MOVE_CYCLES     = 4,
    parameter int unsigned FOG_ON_CYCLES   = 6,
    parameter int unsigned FOG_COOL_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_oh,
    output logic        enabled,
    output logic [1:0]  color,
    output logic        sound_active,
    output logic [1:0]  sound_id,
    output logic        hands,
    output logic        jaw,
    output logic        fog_on,
    output logic        fog_cool,
    output logic        err,
    output logic [7:0]  cmd_count
);

    localparam int unsigned SW      = $clog2(SOUND_CYCLES + 1);
    localparam int unsigned MW      = $clog2(MOVE_CYCLES + 1);
    localparam int unsigned FOG_MAX = (FOG_ON_CYCLES > FOG_COOL_CYCLES) ? FOG_ON_CYCLES
                                                                         : FOG_COOL_CYCLES;
    localparam int unsigned FW      = $clog2(FOG_MAX + 1);

    typedef enum logic {
        SND_IDLE = 1'b0,
        SND_PLAY = 1'b1
    } snd_state_e;

    typedef enum logic [1:0] {
        FOG_IDLE = 2'b00,
        FOG_ON   = 2'b01,
        FOG_COOL = 2'b10
    } fog_state_e;

    logic          enabled_q, enabled_d;
    logic [1:0]    color_q, color_d;
    logic          err_q, err_d;
    logic [7:0]    cmd_count_q, cmd_count_d;

    snd_state_e    snd_state_q, snd_state_d;
    logic [1:0]    snd_id_q, snd_id_d;
    logic [SW-1:0] snd_cnt_q, snd_cnt_d;
    logic          pend_valid_q, pend_valid_d;
    logic [1:0]    pend_id_q, pend_id_d;

    // Index 0 is hands, index 1 is jaw; both run identical retriggerable timers.
    logic [1:0]    mv_q, mv_d;
    logic [MW-1:0] mv_cnt_q [2];
    logic [MW-1:0] mv_cnt_d [2];

    fog_state_e    fog_state_q, fog_state_d;
    logic [FW-1:0] fog_cnt_q, fog_cnt_d;

    logic          oh_ok;
    logic          accept;
    logic          soft_rst;
    logic          snd_cmd;
    logic [1:0]    snd_cmd_id;
    logic [1:0]    mv_cmd;
    logic          fog_cmd;

    // NOTE: every signal gets its default at the top of the block so no path leaves it unassigned (no latches).
    always_comb begin
        oh_ok      = (cmd_oh != '0) && ((cmd_oh & (cmd_oh - 16'd1)) == '0);
        accept     = cmd_valid && oh_ok && (enabled_q || cmd_oh[0]);
        soft_rst   = accept && cmd_oh[1];
        snd_cmd    = accept && (|cmd_oh[10:8]);
        snd_cmd_id = {cmd_oh[9] | cmd_oh[10], cmd_oh[8] | cmd_oh[10]};
        mv_cmd     = {accept && cmd_oh[13], accept && cmd_oh[12]};
        fog_cmd    = accept && cmd_oh[14];

        err_d       = err_q | (cmd_valid && !oh_ok);
        cmd_count_d = accept ? cmd_count_q + 8'd1 : cmd_count_q;

        enabled_d = enabled_q;
        if (accept && cmd_oh[0]) begin
            enabled_d = 1'b1;
        end else if (soft_rst) begin
            enabled_d = 1'b0;
        end

        color_d = color_q;
        if (accept && (|cmd_oh[6:4])) begin
            color_d = {cmd_oh[5] | cmd_oh[6], cmd_oh[4] | cmd_oh[6]};
        end else if (soft_rst) begin
            color_d = 2'b00;
        end

        // Sound player: a command arriving on the final PLAY cycle starts next, ahead of pending.
        snd_state_d  = snd_state_q;
        snd_id_d     = snd_id_q;
        snd_cnt_d    = snd_cnt_q;
        pend_valid_d = pend_valid_q;
        pend_id_d    = pend_id_q;
        case (snd_state_q)
            SND_IDLE: begin
                if (snd_cmd) begin
                    snd_state_d = SND_PLAY;
                    snd_id_d    = snd_cmd_id;
                    snd_cnt_d   = SW'(SOUND_CYCLES - 1);
                end
            end
            SND_PLAY: begin
                if (snd_cnt_q == '0) begin
                    pend_valid_d = 1'b0;
                    if (snd_cmd) begin
                        snd_id_d  = snd_cmd_id;
                        snd_cnt_d = SW'(SOUND_CYCLES - 1);
                    end else if (pend_valid_q) begin
                        snd_id_d  = pend_id_q;
                        snd_cnt_d = SW'(SOUND_CYCLES - 1);
                    end else begin
                        snd_state_d = SND_IDLE;
                        snd_id_d    = 2'b00;
                    end
                end else begin
                    snd_cnt_d = snd_cnt_q - SW'(1);
                    if (snd_cmd) begin
                        pend_valid_d = 1'b1;
                        pend_id_d    = snd_cmd_id;
                    end
                end
            end
            default: snd_state_d = SND_IDLE;
        endcase
        if (soft_rst) begin
            snd_state_d  = SND_IDLE;
            snd_id_d     = 2'b00;
            snd_cnt_d    = '0;
            pend_valid_d = 1'b0;
            pend_id_d    = 2'b00;
        end

        for (int i = 0; i < 2; i++) begin
            mv_d[i]     = mv_q[i];
            mv_cnt_d[i] = mv_cnt_q[i];
            if (mv_cmd[i]) begin
                mv_d[i]     = 1'b1;
                mv_cnt_d[i] = MW'(MOVE_CYCLES - 1);
            end else if (mv_q[i]) begin
                if (mv_cnt_q[i] == '0) begin
                    mv_d[i] = 1'b0;
                end else begin
                    mv_cnt_d[i] = mv_cnt_q[i] - MW'(1);
                end
            end
            if (soft_rst) begin
                mv_d[i]     = 1'b0;
                mv_cnt_d[i] = '0;
            end
        end

        // Fog never jumps straight to IDLE: soft reset only shortens ON into COOL.
        fog_state_d = fog_state_q;
        fog_cnt_d   = fog_cnt_q;
        case (fog_state_q)
            FOG_IDLE: begin
                if (fog_cmd) begin
                    fog_state_d = FOG_ON;
                    fog_cnt_d   = FW'(FOG_ON_CYCLES - 1);
                end
            end
            FOG_ON: begin
                if (soft_rst || fog_cnt_q == '0) begin
                    fog_state_d = FOG_COOL;
                    fog_cnt_d   = FW'(FOG_COOL_CYCLES - 1);
                end else begin
                    fog_cnt_d = fog_cnt_q - FW'(1);
                end
            end
            FOG_COOL: begin
                if (fog_cnt_q == '0) begin
                    fog_state_d = FOG_IDLE;
                end else begin
                    fog_cnt_d = fog_cnt_q - FW'(1);
                end
            end
            default: fog_state_d = FOG_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enabled_q    <= 1'b0;
            color_q      <= 2'b00;
            err_q        <= 1'b0;
            cmd_count_q  <= 8'd0;
            snd_state_q  <= SND_IDLE;
            snd_id_q     <= 2'b00;
            snd_cnt_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= 2'b00;
            mv_q         <= 2'b00;
            mv_cnt_q[0]  <= '0;
            mv_cnt_q[1]  <= '0;
            fog_state_q  <= FOG_IDLE;
            fog_cnt_q    <= '0;
        end else begin
            enabled_q    <= enabled_d;
            color_q      <= color_d;
            err_q        <= err_d;
            cmd_count_q  <= cmd_count_d;
            snd_state_q  <= snd_state_d;
            snd_id_q     <= snd_id_d;
            snd_cnt_q    <= snd_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
            mv_q         <= mv_d;
            mv_cnt_q[0]  <= mv_cnt_d[0];
            mv_cnt_q[1]  <= mv_cnt_d[1];
            fog_state_q  <= fog_state_d;
            fog_cnt_q    <= fog_cnt_d;
        end
    end

    assign enabled      = enabled_q;
    assign color        = color_q;
    assign sound_active = (snd_state_q == SND_PLAY);
    assign sound_id     = snd_id_q;
    assign hands        = mv_q[0];
    assign jaw          = mv_q[1];
    assign fog_on       = (fog_state_q == FOG_ON);
    assign fog_cool     = (fog_state_q == FOG_COOL);
    assign err          = err_q;
    assign cmd_count    = cmd_count_q;

endmodule

// File: tb/tb_haunt_effect_ctrl.sv
// Directed self-checking bench for haunt_effect_ctrl with hand-computed
// expected values; cycle t is the cycle after the t-th sampling edge of a test.
module tb_haunt_effect_ctrl;

    localparam logic [15:0] C_ON     = 16'h0001;
    localparam logic [15:0] C_RESET  = 16'h0002;
    localparam logic [15:0] C_NOOP   = 16'h0004;
    localparam logic [15:0] C_GREEN  = 16'h0010;
    localparam logic [15:0] C_ORANGE = 16'h0040;
    localparam logic [15:0] C_SCREAM = 16'h0100;
    localparam logic [15:0] C_CACKLE = 16'h0200;
    localparam logic [15:0] C_BOO    = 16'h0400;
    localparam logic [15:0] C_HANDS  = 16'h1000;
    localparam logic [15:0] C_JAW    = 16'h2000;
    localparam logic [15:0] C_FOG    = 16'h4000;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic [15:0] cmd_oh;
    logic        enabled;
    logic [1:0]  color;
    logic        sound_active;
    logic [1:0]  sound_id;
    logic        hands;
    logic        jaw;
    logic        fog_on;
    logic        fog_cool;
    logic        err;
    logic [7:0]  cmd_count;

    int n_checks = 0;
    int n_pass   = 0;

    haunt_effect_ctrl #(
        .SOUND_CYCLES   (8),
        .MOVE_CYCLES    (4),
        .FOG_ON_CYCLES  (6),
        .FOG_COOL_CYCLES(10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_oh      (cmd_oh),
        .enabled     (enabled),
        .color       (color),
        .sound_active(sound_active),
        .sound_id    (sound_id),
        .hands       (hands),
        .jaw         (jaw),
        .fog_on      (fog_on),
        .fog_cool    (fog_cool),
        .err         (err),
        .cmd_count   (cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance past the next sampling edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [15:0] oh);
        cmd_valid = 1'b1;
        cmd_oh    = oh;
        tick();
        cmd_valid = 1'b0;
        cmd_oh    = '0;
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] oh;
        int t;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_oh    = '0;
        #12;
        check("rst_enabled", 32'(enabled), 32'd0);
        check("rst_color", 32'(color), 32'd0);
        check("rst_sound", 32'({sound_active, sound_id}), 32'd0);
        check("rst_move", 32'({hands, jaw}), 32'd0);
        check("rst_fog", 32'({fog_on, fog_cool}), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(cmd_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Enable gating
        cyc(C_GREEN);
        check("gate_color", 32'(color), 32'd0);
        check("gate_count", 32'(cmd_count), 32'd0);
        cyc(C_ON);
        check("on_enabled", 32'(enabled), 32'd1);
        cyc(C_GREEN);
        check("green_color", 32'(color), 32'd1);
        check("green_count", 32'(cmd_count), 32'd2);

        // Sound queue: scream@0, cackle@2, boo@3
        for (int c = 0; c < 17; c++) begin
            case (c)
                0:       oh = C_SCREAM;
                2:       oh = C_CACKLE;
                3:       oh = C_BOO;
                default: oh = '0;
            endcase
            if (oh != '0) cyc(oh); else tick();
            t = c + 1;
            check($sformatf("snd_active_t%0d", t), 32'(sound_active), (t <= 16) ? 32'd1 : 32'd0);
            check($sformatf("snd_id_t%0d", t), 32'(sound_id),
                  (t <= 8) ? 32'd1 : (t <= 16) ? 32'd3 : 32'd0);
        end
        check("snd_count", 32'(cmd_count), 32'd5);

        // Fog lockout: fog@0, @10 (dropped, counted), @17
        for (int c = 0; c < 20; c++) begin
            oh = (c == 0 || c == 10 || c == 17) ? C_FOG : 16'h0000;
            if (oh != '0) cyc(oh); else tick();
            t = c + 1;
            check($sformatf("fog_on_t%0d", t), 32'(fog_on),
                  ((t >= 1 && t <= 6) || t >= 18) ? 32'd1 : 32'd0);
            check($sformatf("fog_cool_t%0d", t), 32'(fog_cool),
                  (t >= 7 && t <= 16) ? 32'd1 : 32'd0);
        end
        check("fog_count", 32'(cmd_count), 32'd8);
        repeat (14) tick();
        check("fog_idle", 32'({fog_on, fog_cool}), 32'd0);

        // Movement retrigger: jaw@0,@3; hands@1
        for (int c = 0; c < 9; c++) begin
            case (c)
                0, 3:    oh = C_JAW;
                1:       oh = C_HANDS;
                default: oh = '0;
            endcase
            if (oh != '0) cyc(oh); else tick();
            t = c + 1;
            check($sformatf("jaw_t%0d", t), 32'(jaw), (t >= 1 && t <= 7) ? 32'd1 : 32'd0);
            check($sformatf("hands_t%0d", t), 32'(hands), (t >= 2 && t <= 5) ? 32'd1 : 32'd0);
        end
        check("mv_count", 32'(cmd_count), 32'd11);

        // Soft reset mid-effect
        cyc(C_ORANGE);
        cyc(C_BOO);
        cyc(C_FOG);
        check("pre_color", 32'(color), 32'd3);
        check("pre_sound", 32'({sound_active, sound_id}), 32'h7);
        check("pre_fog_on", 32'(fog_on), 32'd1);
        cyc(C_RESET);
        check("srst_enabled", 32'(enabled), 32'd0);
        check("srst_color", 32'(color), 32'd0);
        check("srst_sound", 32'({sound_active, sound_id}), 32'd0);
        check("srst_fog_on", 32'(fog_on), 32'd0);
        check("srst_count", 32'(cmd_count), 32'd15);
        for (int i = 1; i <= 10; i++) begin
            check($sformatf("srst_cool_%0d", i), 32'(fog_cool), 32'd1);
            tick();
        end
        check("srst_cool_end", 32'({fog_on, fog_cool}), 32'd0);

        // Illegal commands
        cyc(16'h0030);
        check("ill_err", 32'(err), 32'd1);
        check("ill_count", 32'(cmd_count), 32'd15);
        cyc(C_ON);
        check("ill_on_count", 32'(cmd_count), 32'd16);
        cyc(16'h0000);
        check("zero_err", 32'(err), 32'd1);
        check("zero_count", 32'(cmd_count), 32'd16);

        // Asynchronous reset mid-movement
        cyc(C_JAW);
        check("pre_rst_jaw", 32'(jaw), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_jaw", 32'(jaw), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_enabled", 32'(enabled), 32'd0);
        check("arst_count", 32'(cmd_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Counter wrap
        cyc(C_ON);
        repeat (254) cyc(C_NOOP);
        check("wrap_255", 32'(cmd_count), 32'd255);
        cyc(C_NOOP);
        check("wrap_0", 32'(cmd_count), 32'd0);
        check("wrap_err", 32'(err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
